winograd_tile_buffer: RTL and testbench

WINOGRAD_TILE_BUFFER -- requirements
Module: winograd_tile_buffer

---
 rtl/winograd_pkg.sv | 15 +
 rtl/winograd_line_ram.sv | 40 ++++
 rtl/winograd_tile_buffer.sv | 146 ++++++++++++++
 tb/tb_winograd_tile_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and FSM state encoding for the Winograd F(2x2,3x3) input tile buffer.
package winograd_pkg;

    localparam int PIX_W  = 8;
    localparam int TILE   = 4;
    localparam int STRIDE = 2;
    localparam int KER    = 3;

    typedef enum logic [1:0] {
        FILL4 = 2'd0,
        EMIT  = 2'd1,
        FILL2 = 2'd2
    } state_t;

endpackage

// File: rtl/winograd_line_ram.sv
// Four-row ring of image lines with one write port and a 4x4 window read.
// The window read forwards a same-cycle write so a tile can be captured on the final pixel's edge.
module winograd_line_ram
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_slot,
    input  logic [COL_W-1:0]             wr_col,
    input  logic [PIX_W-1:0]             wr_data,
    input  logic [1:0]                   rd_slot,
    input  logic [COL_W-1:0]             rd_col,
    output logic [TILE*TILE*PIX_W-1:0]   rd_tile
);

    logic [PIX_W-1:0] mem [TILE][IMG_W];

    // NOTE: line storage has no reset; every slot is rewritten before a tile reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    // Slot index wraps mod 4 through 2-bit arithmetic, giving logical row order.
    for (genvar r = 0; r < TILE; r++) begin : g_row
        for (genvar c = 0; c < TILE; c++) begin : g_col
            logic [1:0]       slot;
            logic [COL_W-1:0] col;
            assign slot = rd_slot + 2'(r);
            assign col  = rd_col + COL_W'(c);
            assign rd_tile[PIX_W*(TILE*r+c) +: PIX_W] =
                (wr_en && wr_slot == slot && wr_col == col) ? wr_data : mem[slot][col];
        end
    end

endmodule

// File: rtl/winograd_tile_buffer.sv
// Buffers a raster pixel stream in a 4-line ring and emits overlapping 4x4 tiles at stride 2,
// plus a writable 3x3 kernel register.
module winograd_tile_buffer
    import winograd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    output logic         s_ready,
    input  logic         k_we,
    input  logic [3:0]   k_addr,
    input  logic [7:0]   k_data,
    output logic [71:0]  k_out,
    output logic         t_valid,
    input  logic         t_ready,
    output logic [127:0] t_tile,
    output logic [7:0]   t_row,
    output logic [7:0]   t_col,
    output logic         t_last
);

    localparam int         COL_W     = $clog2(IMG_W);
    localparam logic [7:0] LAST_COL  = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_TCOL = 8'(IMG_W - TILE);
    localparam logic [7:0] LAST_TROW = 8'(IMG_H - TILE);
    localparam logic [3:0] LAST_KADR = 4'(KER*KER - 1);

    state_t       state;
    logic [7:0]   in_row;
    logic [7:0]   in_col;
    logic         accept;
    logic         fill_done;
    logic         load_tile;
    logic [7:0]   nxt_row;
    logic [7:0]   nxt_col;
    logic [7:0]   fill_end_row;
    logic [127:0] rd_tile;

    assign accept = s_valid && s_ready;

    // Origin of the tile to be loaded next, and the image row that completes the current fill.
    always_comb begin
        nxt_row      = '0;
        nxt_col      = '0;
        fill_end_row = 8'(TILE - 1);
        case (state)
            FILL2: begin
                nxt_row      = t_row + 8'(STRIDE);
                fill_end_row = t_row + 8'(TILE + 1);
            end
            EMIT: begin
                nxt_row = t_row;
                nxt_col = t_col + 8'(STRIDE);
            end
            default: ;
        endcase
    end

    assign fill_done = accept && (in_col == LAST_COL) && (in_row == fill_end_row);
    assign load_tile = (state == EMIT) ? (t_ready && t_col != LAST_TCOL) : fill_done;

    winograd_line_ram #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_slot (in_row[1:0]),
        .wr_col  (in_col[COL_W-1:0]),
        .wr_data (s_data),
        .rd_slot (nxt_row[1:0]),
        .rd_col  (nxt_col[COL_W-1:0]),
        .rd_tile (rd_tile)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL4;
            in_row  <= '0;
            in_col  <= '0;
            s_ready <= 1'b1;
            t_valid <= 1'b0;
            t_tile  <= '0;
            t_row   <= '0;
            t_col   <= '0;
            t_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (in_col == LAST_COL) begin
                    in_col <= '0;
                    in_row <= in_row + 8'd1;
                end else begin
                    in_col <= in_col + 8'd1;
                end
            end

            if (load_tile) begin
                t_valid <= 1'b1;
                t_tile  <= rd_tile;
                t_row   <= nxt_row;
                t_col   <= nxt_col;
                t_last  <= (nxt_row == LAST_TROW) && (nxt_col == LAST_TCOL);
            end

            case (state)
                FILL4, FILL2: begin
                    if (fill_done) begin
                        state   <= EMIT;
                        s_ready <= 1'b0;
                    end
                end
                EMIT: begin
                    if (t_ready && t_col == LAST_TCOL) begin
                        t_valid <= 1'b0;
                        s_ready <= 1'b1;
                        if (t_row == LAST_TROW) begin
                            state  <= FILL4;
                            in_row <= '0;
                            in_col <= '0;
                            t_row  <= '0;
                            t_col  <= '0;
                        end else begin
                            state <= FILL2;
                        end
                    end
                end
                default: state <= FILL4;
            endcase
        end
    end

    // Kernel is only writable between frames, while no tile is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_out <= '0;
        end else if (k_we && state == FILL4 && !t_valid && k_addr <= LAST_KADR) begin
            k_out[{k_addr, 3'b000} +: PIX_W] <= k_data;
        end
    end

endmodule

// File: tb/tb_winograd_tile_buffer.sv
// Randomized self-checking bench: tiles are compared against a frame-array reference model.
module tb_winograd_tile_buffer;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 8;
    localparam int N_TILES = ((IMG_H - 2) / 2) * ((IMG_W - 2) / 2);

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic         k_we;
    logic [3:0]   k_addr;
    logic [7:0]   k_data;
    logic [71:0]  k_out;
    logic         t_valid;
    logic         t_ready;
    logic [127:0] t_tile;
    logic [7:0]   t_row;
    logic [7:0]   t_col;
    logic         t_last;

    typedef struct packed {
        logic [127:0] tile;
        logic [7:0]   row;
        logic [7:0]   col;
        logic         last;
    } tile_t;

    tile_t       exp_q[$];
    tile_t       prev_t;
    tile_t       first_t;
    tile_t       last_t;
    logic [7:0]  img [IMG_H][IMG_W];
    logic [71:0] exp_k;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          tiles_seen = 0;
    int          stall_left = 0;
    bit          rand_ready = 1'b0;
    bit          stall_arm  = 1'b0;
    bit          stalled_prev = 1'b0;
    bit          first_cap = 1'b0;

    always #5 clk = ~clk;

    winograd_tile_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .k_we    (k_we),
        .k_addr  (k_addr),
        .k_data  (k_data),
        .k_out   (k_out),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .t_tile  (t_tile),
        .t_row   (t_row),
        .t_col   (t_col),
        .t_last  (t_last)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic make_frame(input bit pattern);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = pattern ? 8'(IMG_W * r + c) : 8'($urandom);
    endtask

    // Reference: every stride-2 4x4 window of the frame, in emission order.
    task automatic queue_tiles();
        for (int orow = 0; orow <= IMG_H - 4; orow += 2) begin
            for (int ocol = 0; ocol <= IMG_W - 4; ocol += 2) begin
                tile_t t;
                t.tile = '0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        t.tile[8*(4*r+c) +: 8] = img[orow+r][ocol+c];
                t.row  = 8'(orow);
                t.col  = 8'(ocol);
                t.last = (orow == IMG_H - 4) && (ocol == IMG_W - 4);
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic push_pixel(input logic [7:0] p, input int gap_max);
        int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        int w = 0;
        @(negedge clk);
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = p;
        while (!s_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check("s_ready_timeout", s_ready, 1);
        @(posedge clk);
    endtask

    task automatic stream_frame(input int gap_max);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                push_pixel(img[r][c], gap_max);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain_frame();
        int w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("frame_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("tiles_per_frame", tiles_seen, N_TILES);
    endtask

    task automatic monitor();
        tile_t cur;
        tile_t e;
        bit    rdy;
        forever begin
            @(negedge clk);
            if (rst) begin
                t_ready      = 1'b1;
                stalled_prev = 1'b0;
                stall_left   = 0;
            end else begin
                cur = {t_tile, t_row, t_col, t_last};
                if (stalled_prev) begin
                    check("hold_valid", t_valid, 1);
                    check("hold_tile", t_tile, prev_t.tile);
                    check("hold_pos", {t_row, t_col, t_last}, {prev_t.row, prev_t.col, prev_t.last});
                end
                stalled_prev = 1'b0;
                if (t_valid) begin
                    check("s_ready_emit", s_ready, 0);
                    if (stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else if (stall_arm && t_row == 8'd0 && t_col == 8'd2) begin
                        stall_arm  = 1'b0;
                        stall_left = 4;
                        rdy        = 1'b0;
                        check("stall_tile_b00", t_tile[7:0], 8'd2);
                    end else begin
                        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    t_ready = rdy;
                    if (rdy) begin
                        tiles_seen++;
                        check("tile_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("tile_data", cur.tile, e.tile);
                            check("tile_pos", {cur.row, cur.col, cur.last}, {e.row, e.col, e.last});
                        end
                        if (first_cap) begin
                            first_t   = cur;
                            first_cap = 1'b0;
                        end
                        if (cur.last) last_t = cur;
                    end else begin
                        stalled_prev = 1'b1;
                        prev_t       = cur;
                    end
                end else begin
                    t_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_t_valid"}, t_valid, 0);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_t_tile"}, t_tile, 0);
        check({tag, "_t_pos"}, {t_row, t_col, t_last}, 0);
    endtask

    task automatic main_seq();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        k_we    = 1'b0;
        k_addr  = '0;
        k_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_k_out", k_out, 0);
        rst = 1'b0;

        // Kernel load, including an out-of-range address that must be ignored.
        exp_k = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            k_we   = 1'b1;
            k_addr = 4'(i);
            k_data = 8'(i + 1);
            exp_k[8*i +: 8] = 8'(i + 1);
        end
        @(negedge clk);
        k_addr = 4'd9;
        k_data = 8'hFF;
        @(negedge clk);
        k_we = 1'b0;
        @(negedge clk);
        check("k_out_load", k_out, exp_k);

        // Frame A: ramp pattern, stall on tile (0,2), kernel write attempted during EMIT.
        make_frame(1'b1);
        queue_tiles();
        tiles_seen = 0;
        first_cap  = 1'b1;
        stall_arm  = 1'b1;
        rand_ready = 1'b0;
        fork
            stream_frame(0);
            begin
                int w = 0;
                while (!t_valid && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                k_we   = 1'b1;
                k_addr = 4'd0;
                k_data = 8'hAA;
                @(negedge clk);
                k_we = 1'b0;
            end
        join
        drain_frame();
        check("k_out_emit_write", k_out, exp_k);
        check("first_b00", first_t.tile[7:0], 8'd0);
        check("first_b03", first_t.tile[31:24], 8'd3);
        check("first_b33", first_t.tile[127:120], 8'd27);
        check("last_b00", last_t.tile[7:0], 8'd36);
        check("last_b33", last_t.tile[127:120], 8'd63);
        check("last_pos", {last_t.row, last_t.col}, {8'd4, 8'd4});

        // Frame B back to back with the same pattern.
        queue_tiles();
        tiles_seen = 0;
        first_cap  = 1'b1;
        stream_frame(0);
        drain_frame();
        check("frameB_first_pos", {first_t.row, first_t.col}, 0);
        check("frameB_first_b00", first_t.tile[7:0], 8'd0);

        // Abandon a frame part way through with reset.
        for (int i = 0; i < 20; i++) push_pixel(8'(i + 100), 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        queue_tiles();
        tiles_seen = 0;
        first_cap  = 1'b1;
        stream_frame(1);
        drain_frame();
        check("post_reset_b00", first_t.tile[7:0], 8'd0);

        // Random frames with bursty input and random back-pressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            make_frame(1'b0);
            queue_tiles();
            tiles_seen = 0;
            stream_frame(3);
            drain_frame();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    initial begin
        fork
            monitor();
            main_seq();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_any
    end

endmodule
